// File: rtl/pipe_run_ctrl_if.sv
// rtl/pipe_run_ctrl_if.sv - pipeline, control and status signal bundle for pipe_run_ctrl
interface pipe_run_ctrl_if #(
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32,
  parameter int NSTALL = 4
);
  logic [PC_W-1:0]         f_predPC;
  logic                    F_stall;
  logic [NSTALL-1:0]       stall_src;
  logic [3:0]              W_stat;
  logic [3:0]              W_icode;
  logic                    resume;
  logic [PC_W-1:0]         restart_pc;
  logic                    clr_cnt;
  logic [PC_W-1:0]         F_predPC;
  logic                    run;
  logic                    halted;
  logic                    fault;
  logic [3:0]              halt_code;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [CNT_W-1:0]        retired_cnt;
  logic [CNT_W-1:0]        bubble_cnt;
  logic [NSTALL*CNT_W-1:0] stall_cnt;

  modport master (
    output f_predPC, F_stall, stall_src, W_stat, W_icode, resume, restart_pc, clr_cnt,
    input  F_predPC, run, halted, fault, halt_code, cycle_cnt, retired_cnt, bubble_cnt, stall_cnt
  );

  modport slave (
    input  f_predPC, F_stall, stall_src, W_stat, W_icode, resume, restart_pc, clr_cnt,
    output F_predPC, run, halted, fault, halt_code, cycle_cnt, retired_cnt, bubble_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// rtl/pipe_run_ctrl.sv - Y86 pipeline run/retire controller with saturating performance counters
module pipe_run_ctrl #(
  parameter int              PC_W         = 64,
  parameter int              CNT_W        = 32,
  parameter int              NSTALL       = 4,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter logic [3:0]      BUBBLE_ICODE = 4'h1,
  parameter int              MAX_CYCLES   = 0
) (
  input logic            clk,
  input logic            rst,
  pipe_run_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Last cycle_cnt value of the watchdog window; only meaningful when MAX_CYCLES != 0.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t                  state;
  logic [PC_W-1:0]         pred_pc;
  logic [3:0]              code;
  logic [CNT_W-1:0]        cycles;
  logic [CNT_W-1:0]        retired;
  logic [CNT_W-1:0]        bubbles;
  logic [NSTALL*CNT_W-1:0] stalls;

  logic in_run;
  logic is_hlt;
  logic is_bad;
  logic wd_hit;
  logic retire_ev;
  logic bubble_ev;

  assign in_run    = (state == S_RUN);
  assign is_hlt    = (bus.W_stat == 4'd4);
  assign is_bad    = (bus.W_stat == 4'd2) || (bus.W_stat == 4'd3) || (bus.W_stat >= 4'd5);
  assign wd_hit    = (MAX_CYCLES != 0) && (cycles == WD_LAST);
  assign retire_ev = ((bus.W_stat == 4'd1) || (bus.W_stat == 4'd4)) && (bus.W_icode != BUBBLE_ICODE);
  assign bubble_ev = (bus.W_stat == 4'd0) || ((bus.W_stat == 4'd1) && (bus.W_icode == BUBBLE_ICODE));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // Run/stop FSM; the fetch PC only advances on RUN edges that neither stall nor stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      pred_pc <= RESET_PC;
      code    <= 4'h1;
    end else begin
      case (state)
        S_RUN: begin
          if (is_hlt) begin
            state <= S_HALTED;
            code  <= 4'h4;
          end else if (is_bad) begin
            state <= S_FAULT;
            code  <= bus.W_stat;
          end else if (wd_hit) begin
            state <= S_FAULT;
            code  <= 4'hF;
          end else if (!bus.F_stall) begin
            pred_pc <= bus.f_predPC;
          end
        end
        S_HALTED, S_FAULT: begin
          if (bus.resume) begin
            state   <= S_RUN;
            pred_pc <= bus.restart_pc;
            code    <= 4'h1;
          end
        end
        default: begin
          state <= S_RUN;
          code  <= 4'h1;
        end
      endcase
    end
  end

  // Performance counters: count only while running (stopping edge included), clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      retired <= '0;
      bubbles <= '0;
      stalls  <= '0;
    end else if (bus.clr_cnt) begin
      cycles  <= '0;
      retired <= '0;
      bubbles <= '0;
      stalls  <= '0;
    end else if (in_run) begin
      cycles  <= sat_inc(cycles, 1'b1);
      retired <= sat_inc(retired, retire_ev);
      bubbles <= sat_inc(bubbles, bubble_ev);
      for (int i = 0; i < NSTALL; i++) begin
        stalls[i*CNT_W +: CNT_W] <= sat_inc(stalls[i*CNT_W +: CNT_W], bus.stall_src[i]);
      end
    end
  end

  assign bus.F_predPC    = pred_pc;
  assign bus.run         = (state == S_RUN);
  assign bus.halted      = (state == S_HALTED);
  assign bus.fault       = (state == S_FAULT);
  assign bus.halt_code   = code;
  assign bus.cycle_cnt   = cycles;
  assign bus.retired_cnt = retired;
  assign bus.bubble_cnt  = bubbles;
  assign bus.stall_cnt   = stalls;
endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Synthesizable run/retire controller for the pipelined Y86 processor. Owns the fetch predicted-PC register and the stop decision, which was previously simulation-only status handling. It watches the write-back status and icode, freezes the machine on halt or fault, and supports resume to a restart PC. It also provides saturating performance counters: cycles, retired instructions, bubbles, and one stall counter per stall source. It sits beside the pipeline control logic at processor top level.

Parameters:
PC_W, 64, width of the PC register and PC ports
CNT_W, 32, width of every performance counter
NSTALL, 4, number of independent stall-source inputs, each with its own counter
RESET_PC, 0, value loaded into F_predPC on reset
BUBBLE_ICODE, 4'h1, W_icode value treated as a bubble (nop)
MAX_CYCLES, 0, watchdog limit on RUN cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
f_predPC  in  PC_W  next predicted PC from fetch
F_stall  in  1  fetch stall from pipeline control
stall_src  in  NSTALL  per-source stall indications (bit i = source i)
W_stat  in  4  write-back status: 0 empty, 1 AOK, 2 INS, 3 ADR, 4 HLT, 5-15 illegal
W_icode  in  4  write-back icode
resume  in  1  single-cycle pulse: leave HALTED/FAULT
restart_pc  in  PC_W  PC loaded on resume
clr_cnt  in  1  synchronous clear of all counters
F_predPC  out  PC_W  registered fetch PC
run  out  1  1 in RUN state
halted  out  1  1 in HALTED state
fault  out  1  1 in FAULT state
halt_code  out  4  stop reason
cycle_cnt  out  CNT_W  RUN cycles
retired_cnt  out  CNT_W  retired instructions
bubble_cnt  out  CNT_W  write-back bubbles
stall_cnt  out  NSTALL*CNT_W  per-source stall cycles; source i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=RUN, F_predPC=RESET_PC, halt_code=4'h1.
  - All counters 0; run=1, halted=0, fault=0.
- States: RUN, HALTED, FAULT. Outputs run/halted/fault are decoded from registered state and are mutually exclusive.
- RUN, per rising edge, evaluated in this priority:
  1. W_stat=4 -> HALTED, halt_code=4; the HLT instruction counts as retired.
  2. W_stat in {2,3,5..15} -> FAULT, halt_code=W_stat; not retired.
  3. MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1 -> FAULT, halt_code=4'hF.
  4. Otherwise stay in RUN.
- F_predPC loads f_predPC only when state==RUN, F_stall==0, and no transition occurs on that edge. Otherwise it holds; it is frozen from the stopping edge onward.
- HALTED/FAULT:
  - All inputs except resume, clr_cnt, and rst are ignored.
  - resume=1 -> RUN next edge, F_predPC=restart_pc, halt_code=4'h1.
  - resume in RUN has no effect.
- Counters (only in RUN, including the transition edge):
  - cycle_cnt +1 every RUN cycle.
  - retired_cnt +1 when W_stat in {1,4} and W_icode!=BUBBLE_ICODE.
  - bubble_cnt +1 when W_stat==0, or W_stat==1 and W_icode==BUBBLE_ICODE.
  - stall_cnt[i] +1 when stall_src[i]=1; sources counted independently, simultaneous stalls all increment.
  - All counters saturate at all-ones and never wrap.
- clr_cnt has priority over increment: the counter is 0 after that edge.
  - Clearing does not change state or F_predPC.
  - Clearing cycle_cnt restarts the watchdog window.
- Latency: all outputs are registered; a stop decision is visible one edge after W_stat is sampled.

Test Plan:
- Reset with RESET_PC=0x40, hold f_predPC=0x99, rst pulsed mid-run -> F_predPC=0x40, run=1, all counters 0 immediately (async).
- RUN, F_stall=0, f_predPC 0,10,20 on successive edges -> F_predPC tracks with one-cycle lag; F_stall=1 for 2 cycles -> F_predPC held; stall_cnt[0] +2 with stall_src=4'b0001.
- W_stat=1 with icodes 6,1,3 then W_stat=4 -> retired_cnt=3, bubble_cnt=1, halted=1, halt_code=4; F_predPC frozen for 10 further cycles despite changing f_predPC.
- W_stat=3 -> fault=1, halt_code=3, retired_cnt unchanged; resume with restart_pc=0x100 -> run=1, F_predPC=0x100, halt_code=1.
- MAX_CYCLES=8, no stop status -> fault=1, halt_code=4'hF after exactly 8 RUN cycles, cycle_cnt=8.
- CNT_W=4, stall_src=all ones for 20 cycles -> every stall_cnt lane=4'hF (saturated); clr_cnt asserted together with stall -> all lanes 0.
